aria_round_ctrl: RTL and testbench

Sequencer for the ARIA round datapath: drives the L1 register's enable, opcode, round-key address and LT-variant flag, and hands off to the substitution layer, so that one block is encrypted with a 128/192/256-bit key. It sits between the host-side block interface and the round datapath (L1 layer and substitution layer). It is a pure Moore controller with no data path of its own.

---
 rtl/aria_pkg.sv | 34 +++
 rtl/aria_rk_addr_gen.sv | 22 ++
 rtl/aria_round_ctrl.sv | 134 +++++++++++++
 tb/tb_aria_round_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/aria_pkg.sv
// Shared encodings for the ARIA round sequencer: L1 opcodes, key-length codes,
// round counts and FSM state encoding.
package aria_pkg;

  localparam logic [1:0] OP_INIT = 2'b00;
  localparam logic [1:0] OP_ARK  = 2'b01;
  localparam logic [1:0] OP_LT   = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  localparam logic [1:0] KL_128  = 2'b00;
  localparam logic [1:0] KL_192  = 2'b01;
  localparam logic [1:0] KL_256  = 2'b10;
  localparam logic [1:0] KL_RSVD = 2'b11;

  localparam logic [4:0] NR_128 = 5'd12;
  localparam logic [4:0] NR_192 = 5'd14;
  localparam logic [4:0] NR_256 = 5'd16;

  typedef enum logic [3:0] {
    S_IDLE, S_ARK0, S_ARK1, S_SL_REQ, S_SL_WAIT, S_LOAD,
    S_LT, S_FIN0, S_FIN1, S_DONE, S_CLR
  } state_e;

  // Reserved code maps to 0; callers must never start on it.
  function automatic logic [4:0] nrounds(input logic [1:0] kl);
    case (kl)
      KL_128:  return NR_128;
      KL_192:  return NR_192;
      KL_256:  return NR_256;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/aria_rk_addr_gen.sv
// Round-key selector: phase 0 picks W[p] directly, phase 1 picks
// W[(p+1) mod 4] rotated by class g, where p/g come from (r-1).
module aria_rk_addr_gen (
  input  logic [4:0] r_i,
  input  logic       phase_i,
  output logic [5:0] rk_addr_o
);

  logic [4:0] rm1;
  logic [1:0] p;
  logic [2:0] g;

  assign rm1 = r_i - 5'd1;
  assign p   = rm1[1:0];
  assign g   = rm1[4:2];

  always_comb begin
    if (!phase_i) rk_addr_o = {3'b000, p, 1'b1};
    else          rk_addr_o = {g, p + 2'd1, 1'b0};
  end

endmodule

// File: rtl/aria_round_ctrl.sv
// Moore sequencer for the ARIA round datapath. Outputs are registered from the
// next-state decode so they line up with the state and never see an input combinationally.
module aria_round_ctrl
  import aria_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] key_len,
  input  logic       abort,
  input  logic       sl_done,
  output logic       sl_start,
  output logic       l1_en,
  output logic [1:0] l1_op,
  output logic [5:0] rk_addr,
  output logic       flg_ltinv,
  output logic       r_ready,
  output logic       busy,
  output logic       done
);

  state_e     state_q, state_d;
  logic [4:0] r_q, r_d;
  logic [4:0] n_q, n_d;
  logic [1:0] lt_q, lt_d;

  logic       sl_start_d, l1_en_d, flg_d, r_ready_d, busy_d, done_d;
  logic [1:0] l1_op_d;
  logic [5:0] rk_addr_d, rk_gen;
  logic       rk_phase, rk_sel;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    n_d     = n_q;
    lt_d    = lt_q;
    if (abort) begin
      state_d = S_CLR;
    end else begin
      case (state_q)
        S_IDLE: if (start && key_len != KL_RSVD) begin
          n_d     = nrounds(key_len);
          r_d     = 5'd1;
          state_d = S_ARK0;
        end
        S_ARK0:    state_d = S_ARK1;
        S_ARK1:    state_d = S_SL_REQ;
        S_SL_REQ:  state_d = S_SL_WAIT;
        S_SL_WAIT: if (sl_done) state_d = S_LOAD;
        S_LOAD: begin
          if (r_q < n_q) begin
            lt_d    = 2'd0;
            state_d = S_LT;
          end else begin
            r_d     = r_q + 5'd1;
            state_d = S_FIN0;
          end
        end
        S_LT: begin
          lt_d = lt_q + 2'd1;
          if (lt_q == 2'd3) begin
            r_d     = r_q + 5'd1;
            state_d = S_ARK0;
          end
        end
        S_FIN0:  state_d = S_FIN1;
        S_FIN1:  state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        S_CLR:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign rk_phase = (state_d == S_ARK1) || (state_d == S_FIN1);
  assign rk_sel   = (state_d == S_ARK0) || (state_d == S_ARK1) ||
                    (state_d == S_FIN0) || (state_d == S_FIN1);

  aria_rk_addr_gen u_rk (
    .r_i       (r_d),
    .phase_i   (rk_phase),
    .rk_addr_o (rk_gen)
  );

  // Decode of the state being entered; registered below alongside the state.
  always_comb begin
    sl_start_d = (state_d == S_SL_REQ);
    flg_d      = (state_d == S_LT) && !r_d[0];
    r_ready_d  = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    rk_addr_d  = rk_sel ? rk_gen : 6'd0;
    l1_en_d    = 1'b0;
    l1_op_d    = OP_INIT;
    case (state_d)
      S_ARK0, S_ARK1, S_FIN0, S_FIN1: begin l1_en_d = 1'b1; l1_op_d = OP_ARK; end
      S_LOAD: begin l1_en_d = 1'b1; l1_op_d = OP_INIT; end
      S_LT:   begin l1_en_d = 1'b1; l1_op_d = OP_LT;   end
      S_CLR:  begin l1_en_d = 1'b1; l1_op_d = OP_CLR;  end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      r_q       <= 5'd0;
      n_q       <= 5'd0;
      lt_q      <= 2'd0;
      sl_start  <= 1'b0;
      l1_en     <= 1'b0;
      l1_op     <= OP_INIT;
      rk_addr   <= 6'd0;
      flg_ltinv <= 1'b0;
      r_ready   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      n_q       <= n_d;
      lt_q      <= lt_d;
      sl_start  <= sl_start_d;
      l1_en     <= l1_en_d;
      l1_op     <= l1_op_d;
      rk_addr   <= rk_addr_d;
      flg_ltinv <= flg_d;
      r_ready   <= r_ready_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_aria_round_ctrl.sv
// Directed bench for aria_round_ctrl: a responder model returns sl_done after
// each sl_start and per-cycle traces are checked against hand-computed values.
module tb_aria_round_ctrl;

  logic       clk, rst_n, start, abort, sl_done;
  logic [1:0] key_len;
  logic       sl_start, l1_en, flg_ltinv, r_ready, busy, done;
  logic [1:0] l1_op;
  logic [5:0] rk_addr;

  int n_chk = 0;
  int n_fail = 0;

  logic       en_tr   [0:199];
  logic [1:0] op_tr   [0:199];
  logic       rdy_tr  [0:199];
  logic       busy_tr [0:199];
  logic [5:0] rk_q[$];
  int done_cyc, done_cnt, sl_cnt, ltinv_err, lt_hi, wait_err;

  aria_round_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .abort(abort),
    .sl_done(sl_done), .sl_start(sl_start), .l1_en(l1_en), .l1_op(l1_op),
    .rk_addr(rk_addr), .flg_ltinv(flg_ltinv), .r_ready(r_ready), .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle 1 is the first cycle after the edge that samples start.
  task automatic run_op(input logic [1:0] kl, input int ncyc, input int slow_round,
                        input int slow_dly, input int abort_at, input int stray_at);
    int sreq_cyc, sd_at;
    logic exp_flg;
    done_cyc = -1; done_cnt = 0; sl_cnt = 0; ltinv_err = 0; lt_hi = 0; wait_err = 0;
    rk_q.delete();
    sreq_cyc = -1; sd_at = -1;
    key_len = kl; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      en_tr[c] = l1_en; op_tr[c] = l1_op; rdy_tr[c] = r_ready; busy_tr[c] = busy;
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if (l1_en && l1_op == 2'b01) rk_q.push_back(rk_addr);
      if (c > sreq_cyc && c <= sd_at && l1_en) wait_err++;
      exp_flg = (l1_en && l1_op == 2'b10) ? (sl_cnt % 2 == 0) : 1'b0;
      if (flg_ltinv !== exp_flg) ltinv_err++;
      if (flg_ltinv) lt_hi++;
      sl_done = (c == sd_at);
      if (sl_start) begin
        sl_cnt++;
        sreq_cyc = c;
        sd_at = c + ((sl_cnt == slow_round) ? slow_dly : 1);
      end
      abort = (c == abort_at);
      start = (c == stray_at);
    end
    sl_done = 1'b0; abort = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; sl_done = 1'b0; key_len = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_chk++; if (r_ready !== 1'b1) begin n_fail++; $display("FAIL rst_r_ready: got %b want 1", r_ready); end
    n_chk++; if ({done, sl_start, l1_en, flg_ltinv} !== 4'b0000)
      begin n_fail++; $display("FAIL rst_flags: got %b want 0000", {done, sl_start, l1_en, flg_ltinv}); end
    n_chk++; if ({l1_op, rk_addr} !== 8'h00)
      begin n_fail++; $display("FAIL rst_op_rk: got %h want 00", {l1_op, rk_addr}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (r_ready !== 1'b1 || busy !== 1'b0)
      begin n_fail++; $display("FAIL post_rst_idle: got rdy=%b busy=%b want 1/0", r_ready, busy); end
  endtask

  task automatic test_k128;
    run_op(2'b00, 110, 0, 1, -1, -1);
    n_chk++; if (done_cyc !== 107) begin n_fail++; $display("FAIL k128_done_cycle: got %0d want 107", done_cyc); end
    n_chk++; if (done_cnt !== 1) begin n_fail++; $display("FAIL k128_done_count: got %0d want 1", done_cnt); end
    n_chk++; if (sl_cnt !== 12) begin n_fail++; $display("FAIL k128_sl_start_count: got %0d want 12", sl_cnt); end
    n_chk++;
    if (rk_q.size() !== 26) begin
      n_fail++; $display("FAIL k128_rk_count: got %0d want 26", rk_q.size());
    end else begin
      if ({rk_q[0], rk_q[1], rk_q[2], rk_q[3]} !== {6'b000001, 6'b000010, 6'b000011, 6'b000100}) begin
        n_fail++; $display("FAIL k128_rk_first: got %b %b %b %b want 000001 000010 000011 000100",
                           rk_q[0], rk_q[1], rk_q[2], rk_q[3]);
      end
      n_chk++;
      if ({rk_q[24], rk_q[25]} !== {6'b000001, 6'b011010}) begin
        n_fail++; $display("FAIL k128_rk_fin: got %b %b want 000001 011010", rk_q[24], rk_q[25]);
      end
    end
    n_chk++; if (rdy_tr[108] !== 1'b1 || busy_tr[108] !== 1'b0)
      begin n_fail++; $display("FAIL k128_back_idle: got rdy=%b busy=%b want 1/0", rdy_tr[108], busy_tr[108]); end
    n_chk++; if (ltinv_err !== 0) begin n_fail++; $display("FAIL k128_ltinv: got %0d errors want 0", ltinv_err); end
  endtask

  task automatic test_k256;
    run_op(2'b10, 146, 0, 1, -1, -1);
    n_chk++; if (done_cyc !== 143) begin n_fail++; $display("FAIL k256_done_cycle: got %0d want 143", done_cyc); end
    n_chk++;
    if (rk_q.size() !== 34) begin
      n_fail++; $display("FAIL k256_rk_count: got %0d want 34", rk_q.size());
    end else if ({rk_q[32], rk_q[33]} !== {6'b000001, 6'b100010}) begin
      n_fail++; $display("FAIL k256_rk_fin: got %b %b want 000001 100010", rk_q[32], rk_q[33]);
    end
    n_chk++; if (ltinv_err !== 0) begin n_fail++; $display("FAIL k256_ltinv: got %0d errors want 0", ltinv_err); end
    n_chk++; if (lt_hi !== 28) begin n_fail++; $display("FAIL k256_ltinv_cycles: got %0d want 28", lt_hi); end
  endtask

  task automatic test_k192_slow;
    run_op(2'b01, 132, 3, 5, -1, -1);
    n_chk++; if (done_cyc !== 129) begin n_fail++; $display("FAIL k192_slow_done_cycle: got %0d want 129", done_cyc); end
    n_chk++; if (wait_err !== 0) begin n_fail++; $display("FAIL k192_l1en_in_wait: got %0d want 0", wait_err); end
    n_chk++; if (sl_cnt !== 14) begin n_fail++; $display("FAIL k192_sl_start_count: got %0d want 14", sl_cnt); end
  endtask

  task automatic test_abort;
    run_op(2'b00, 60, 0, 1, 52, -1);
    n_chk++; if (en_tr[52] !== 1'b1 || op_tr[52] !== 2'b10)
      begin n_fail++; $display("FAIL abort_pre_lt: got en=%b op=%b want 1/10", en_tr[52], op_tr[52]); end
    n_chk++; if (en_tr[53] !== 1'b1 || op_tr[53] !== 2'b11)
      begin n_fail++; $display("FAIL abort_clr: got en=%b op=%b want 1/11", en_tr[53], op_tr[53]); end
    n_chk++; if (rdy_tr[54] !== 1'b1 || busy_tr[54] !== 1'b0 || en_tr[54] !== 1'b0)
      begin n_fail++; $display("FAIL abort_idle: got rdy=%b busy=%b en=%b want 1/0/0", rdy_tr[54], busy_tr[54], en_tr[54]); end
    n_chk++; if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d want 0", done_cnt); end
  endtask

  task automatic test_ignore;
    key_len = 2'b11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (busy !== 1'b0 || r_ready !== 1'b1)
      begin n_fail++; $display("FAIL rsvd_keylen_start: got busy=%b rdy=%b want 0/1", busy, r_ready); end
    sl_done = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sl_done = 1'b0;
    n_chk++; if (busy !== 1'b0 || sl_start !== 1'b0 || l1_en !== 1'b0)
      begin n_fail++; $display("FAIL stray_sl_done: got busy=%b sl_start=%b en=%b want 0/0/0", busy, sl_start, l1_en); end
    run_op(2'b00, 110, 0, 1, -1, 20);
    n_chk++; if (done_cyc !== 107 || done_cnt !== 1)
      begin n_fail++; $display("FAIL start_while_busy: got done@%0d x%0d want 107 x1", done_cyc, done_cnt); end
    n_chk++; if (sl_cnt !== 12) begin n_fail++; $display("FAIL start_while_busy_sl: got %0d want 12", sl_cnt); end
  endtask

  task automatic test_async_reset;
    key_len = 2'b00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (busy !== 1'b1 || l1_en !== 1'b0)
      begin n_fail++; $display("FAIL sl_wait_state: got busy=%b en=%b want 1/0", busy, l1_en); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0 || r_ready !== 1'b1 || {done, sl_start, l1_en, flg_ltinv, l1_op, rk_addr} !== 12'h000)
      begin n_fail++; $display("FAIL async_reset: got busy=%b rdy=%b rest=%h want 0/1/000", busy, r_ready,
                                {done, sl_start, l1_en, flg_ltinv, l1_op, rk_addr}); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(2'b00, 110, 0, 1, -1, -1);
    n_chk++; if (done_cyc !== 107) begin n_fail++; $display("FAIL after_reset_done: got %0d want 107", done_cyc); end
  endtask

  initial begin
    test_reset();
    test_k128();
    test_k256();
    test_k192_slow();
    test_abort();
    test_ignore();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
